// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped countdown timer with prescaler and level interrupt
module mmio_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter int unsigned WIDTH     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [15:0] memAddr,
   input  logic [31:0] writeMemData,
   output logic [31:0] memData,
   output logic        hit,
   output logic        irq
);

   logic             en_q, en_d;
   logic             auto_q, auto_d;
   logic             ie_q, ie_d;
   logic [7:0]       presc_q, presc_d;
   logic [7:0]       pcnt_q, pcnt_d;
   logic [WIDTH-1:0] load_q, load_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             expired_q, expired_d;

   logic [1:0]       reg_idx;
   logic             wr_en, wr_ctrl, wr_load, wr_count, wr_status;
   logic             tick;
   logic             unused_addr_lsb;

   // Byte lanes within a register are not distinguished.
   assign unused_addr_lsb = ^memAddr[1:0];

   assign hit       = (memAddr[15:4] == BASE_ADDR[15:4]);
   assign reg_idx   = memAddr[3:2];
   assign wr_en     = MemWrite & hit;
   assign wr_ctrl   = wr_en & (reg_idx == 2'd0);
   assign wr_load   = wr_en & (reg_idx == 2'd1);
   assign wr_count  = wr_en & (reg_idx == 2'd2);
   assign wr_status = wr_en & (reg_idx == 2'd3);
   assign tick      = en_q & (pcnt_q == presc_q);

   // Both terms come straight from flops, so irq has no path from the bus.
   assign irq = expired_q & ie_q;

   // Read mux: registers zero-extended, nothing driven outside the window.
   always_comb begin
      memData = '0;
      if (hit) begin
         case (reg_idx)
            2'd0:    memData = {16'h0000, presc_q, 5'b00000, ie_q, auto_q, en_q};
            2'd1:    memData = 32'(load_q);
            2'd2:    memData = 32'(count_q);
            default: memData = {31'h0, expired_q};
         endcase
      end
   end

   // Next state: prescaler, countdown/expiry, then CPU writes layered on top.
   always_comb begin
      en_d      = en_q;
      auto_d    = auto_q;
      ie_d      = ie_q;
      presc_d   = presc_q;
      load_d    = load_q;
      count_d   = count_q;
      expired_d = expired_q;

      if (!en_q || tick) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + 8'd1;
      end

      // Clear first so that an expiry in the same cycle still sets the flag.
      if (wr_status && writeMemData[0]) begin
         expired_d = 1'b0;
      end
      if (tick && (count_q == '0)) begin
         expired_d = 1'b1;
      end

      // A CTRL or COUNT write in a tick cycle takes precedence over the tick.
      if (tick && !wr_ctrl && !wr_count) begin
         if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
         end else if (auto_q) begin
            count_d = load_q;
         end else begin
            en_d = 1'b0;
         end
      end

      if (wr_ctrl) begin
         en_d    = writeMemData[0];
         auto_d  = writeMemData[1];
         ie_d    = writeMemData[2];
         presc_d = writeMemData[15:8];
         pcnt_d  = '0;
      end
      if (wr_load) begin
         load_d = writeMemData[WIDTH-1:0];
      end
      if (wr_count) begin
         count_d = writeMemData[WIDTH-1:0];
         pcnt_d  = '0;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q      <= 1'b0;
         auto_q    <= 1'b0;
         ie_q      <= 1'b0;
         presc_q   <= '0;
         pcnt_q    <= '0;
         load_q    <= '0;
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         en_q      <= en_d;
         auto_q    <= auto_d;
         ie_q      <= ie_d;
         presc_q   <= presc_d;
         pcnt_q    <= pcnt_d;
         load_q    <= load_d;
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - self-checking bench for mmio_timer
module tb_mmio_timer;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [15:0] memAddr;
   logic [31:0] writeMemData;
   logic [31:0] memData;
   logic        hit;
   logic        irq;

   int total = 0;
   int bad   = 0;

   mmio_timer dut (
      .clk          (clk),
      .reset        (reset),
      .MemWrite     (MemWrite),
      .memAddr      (memAddr),
      .writeMemData (writeMemData),
      .memData      (memData),
      .hit          (hit),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic        m_en, m_auto, m_ie, m_exp;
   logic [7:0]  m_presc, m_pcnt;
   logic [31:0] m_load, m_count;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] data;
      logic [15:0] raddr;
      logic [31:0] exp_rd;
      logic        exp_hit;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[12];

   int t3_cnt[18] = '{2,2,1,1,1,0,0,0,2, 2,2,1,1,1,0,0,0,2};
   int t3_exp[18] = '{0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,1};

   function automatic vec_t mk(input logic we, input logic [15:0] a, input logic [31:0] d,
                               input logic [15:0] ra, input logic [31:0] er,
                               input logic eh, input logic ei);
      vec_t v;
      v.we = we; v.addr = a; v.data = d; v.raddr = ra;
      v.exp_rd = er; v.exp_hit = eh; v.exp_irq = ei;
      return v;
   endfunction

   function automatic logic [31:0] m_ctrl();
      return {16'h0000, m_presc, 5'b00000, m_ie, m_auto, m_en};
   endfunction

   task automatic model_reset();
      m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
      m_presc = 0; m_pcnt = 0; m_load = 0; m_count = 0;
   endtask

   // One clock of the timer, derived from the written rules.
   task automatic model_step(input logic we, input logic [15:0] a, input logic [31:0] d);
      bit          in_win, wr, tk;
      int          idx;
      logic        n_en, n_auto, n_ie, n_exp;
      logic [7:0]  n_presc, n_pcnt;
      logic [31:0] n_load, n_count;
      in_win = (a / 16) == (16'hFF00 / 16);
      wr  = we && in_win;
      idx = (a % 16) / 4;
      tk  = m_en && (m_pcnt == m_presc);
      n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_exp = m_exp;
      n_presc = m_presc; n_load = m_load; n_count = m_count;
      n_pcnt = (m_en && !tk) ? m_pcnt + 1 : 0;
      if (tk) begin
         if (m_count != 0) n_count = m_count - 1;
         else begin
            n_exp = 1;
            if (m_auto) n_count = m_load;
            else n_en = 0;
         end
      end
      if (wr) begin
         case (idx)
            0: begin
               n_en = d[0]; n_auto = d[1]; n_ie = d[2]; n_presc = d[15:8]; n_pcnt = 0;
               n_count = (tk && m_count != 0) ? m_count : n_count;
               if (tk && m_count == 0 && m_auto) n_count = m_count;
            end
            1: n_load = d;
            2: begin n_count = d; n_pcnt = 0; end
            default: if (d[0] && !(tk && m_count == 0)) n_exp = 0;
         endcase
      end
      m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp;
      m_presc = n_presc; m_pcnt = n_pcnt; m_load = n_load; m_count = n_count;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_rd(input string name, input logic [15:0] a, input logic [31:0] exp);
      MemWrite = 1'b0;
      memAddr  = a;
      #1;
      chk(name, memData, exp);
   endtask

   task automatic step(input logic we, input logic [15:0] a, input logic [31:0] d);
      MemWrite = we; memAddr = a; writeMemData = d;
      model_step(we, a, d);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_ctrl"},  {16'h0, 16'hFF00}, {16'h0, 16'hFF00});
      total--;
      chk_rd({tag, "_ctrl"},  16'hFF00, m_ctrl());
      chk_rd({tag, "_load"},  16'hFF04, m_load);
      chk_rd({tag, "_count"}, 16'hFF08, m_count);
      chk_rd({tag, "_stat"},  16'hFF0C, {31'h0, m_exp});
      chk({tag, "_irq"}, {31'h0, irq}, {31'h0, m_exp & m_ie});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; MemWrite = 1'b0; memAddr = 16'h0000; writeMemData = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk_rd("rst_ctrl", 16'hFF00, 32'h0);
      chk_rd("rst_load", 16'hFF04, 32'h0);
      chk_rd("rst_count", 16'hFF08, 32'h0);
      chk_rd("rst_stat", 16'hFF0C, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk_rd("rst_nohit_data", 16'h1234, 32'h0);
      chk("rst_nohit", {31'h0, hit}, 32'h0);

      // Decode and register access table, timer idle
      vecs[0]  = mk(1, 16'hFF04, 32'h0000_0009, 16'hFF04, 32'h0000_0009, 1, 0);
      vecs[1]  = mk(1, 16'hFF10, 32'hDEAD_BEEF, 16'hFF10, 32'h0,         0, 0);
      vecs[2]  = mk(1, 16'hFEFC, 32'h0000_1234, 16'hFF04, 32'h0000_0009, 1, 0);
      vecs[3]  = mk(1, 16'hFF08, 32'h0000_0005, 16'hFF09, 32'h0000_0005, 1, 0);
      vecs[4]  = mk(1, 16'hFF00, 32'hFFFF_FFFF, 16'hFF00, 32'h0000_FF07, 1, 0);
      vecs[5]  = mk(1, 16'hFF00, 32'h0000_0000, 16'hFF08, 32'h0000_0005, 1, 0);
      vecs[6]  = mk(1, 16'hFEF0, 32'hFFFF_FFFF, 16'hFF00, 32'h0,         1, 0);
      vecs[7]  = mk(1, 16'hFF0C, 32'hFFFF_FFFE, 16'hFF0C, 32'h0,         1, 0);
      vecs[8]  = mk(1, 16'hFFFF, 32'h0000_0007, 16'hFF08, 32'h0000_0005, 1, 0);
      vecs[9]  = mk(1, 16'hFF0E, 32'h0000_0001, 16'hFF03, 32'h0,         1, 0);
      vecs[10] = mk(0, 16'hFF04, 32'h0,         16'hFF05, 32'h0000_0009, 1, 0);
      vecs[11] = mk(1, 16'hFF10, 32'h1234_5678, 16'hFEFC, 32'h0,         0, 0);
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].we, vecs[i].addr, vecs[i].data);
         chk_rd($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
         chk($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
         chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      end

      // Reset in the middle of a count
      step(1, 16'hFF08, 32'd5);
      step(1, 16'hFF00, 32'h1);
      step(0, 16'h0000, 32'h0);
      reset = 1'b1;
      chk_rd("midrst_count", 16'hFF08, 32'h0);
      chk_rd("midrst_ctrl", 16'hFF00, 32'h0);
      chk("midrst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) step(0, 16'h0000, 32'h0);
      chk_rd("idle_count", 16'hFF08, 32'h0);
      chk_rd("idle_stat", 16'hFF0C, 32'h0);
      chk_rd("idle_ctrl", 16'hFF00, 32'h0);

      // One-shot run, PRESC=0
      step(1, 16'hFF04, 32'd3);
      step(1, 16'hFF08, 32'd3);
      step(1, 16'hFF00, 32'h5);
      chk_rd("os_count0", 16'hFF08, 32'd3);
      for (int k = 1; k <= 4; k++) begin
         step(0, 16'h0000, 32'h0);
         chk_rd($sformatf("os_count%0d", k), 16'hFF08, (k < 3) ? 32'(3 - k) : 32'h0);
         chk_rd($sformatf("os_stat%0d", k), 16'hFF0C, (k == 4) ? 32'h1 : 32'h0);
         chk($sformatf("os_irq%0d", k), {31'h0, irq}, (k == 4) ? 32'h1 : 32'h0);
      end
      chk_rd("os_ctrl_after", 16'hFF00, 32'h4);
      step(0, 16'h0000, 32'h0);
      step(0, 16'h0000, 32'h0);
      chk_rd("os_count_hold", 16'hFF08, 32'h0);
      chk_rd("os_stat_hold", 16'hFF0C, 32'h1);

      // Auto-reload with PRESC=2, W1C at k=10
      do_reset();
      step(1, 16'hFF04, 32'd2);
      step(1, 16'hFF08, 32'd2);
      step(1, 16'hFF00, 32'h0203);
      for (int k = 1; k <= 18; k++) begin
         if (k == 10) step(1, 16'hFF0C, 32'h1);
         else         step(0, 16'h0000, 32'h0);
         chk_rd($sformatf("ar_count%0d", k), 16'hFF08, 32'(t3_cnt[k-1]));
         chk_rd($sformatf("ar_stat%0d", k), 16'hFF0C, 32'(t3_exp[k-1]));
         chk($sformatf("ar_irq%0d", k), {31'h0, irq}, 32'h0);
      end

      // Collisions
      step(0, 16'h0000, 32'h0);
      step(0, 16'h0000, 32'h0);
      step(1, 16'hFF08, 32'd7);
      chk_rd("col_count_write_wins", 16'hFF08, 32'd7);
      step(1, 16'hFF0C, 32'h1);
      chk_rd("col_stat_cleared", 16'hFF0C, 32'h0);
      step(1, 16'hFF08, 32'd0);
      step(0, 16'h0000, 32'h0);
      step(0, 16'h0000, 32'h0);
      chk_rd("col_stat_pre", 16'hFF0C, 32'h0);
      step(1, 16'hFF0C, 32'h1);
      chk_rd("col_set_wins", 16'hFF0C, 32'h1);
      chk_rd("col_reload", 16'hFF08, 32'd2);

      // irq gating by IE
      step(1, 16'hFF00, 32'h0203);
      chk("gate_irq_off", {31'h0, irq}, 32'h0);
      chk_rd("gate_stat_kept", 16'hFF0C, 32'h1);
      step(1, 16'hFF00, 32'h0207);
      chk("gate_irq_on", {31'h0, irq}, 32'h1);
      chk_rd("gate_stat_on", 16'hFF0C, 32'h1);
      step(1, 16'hFF0C, 32'h1);
      chk("gate_irq_clr", {31'h0, irq}, 32'h0);

      // Randomized traffic against the reference model
      do_reset();
      for (int n = 0; n < 300; n++) begin
         int          r, idx;
         logic [15:0] a;
         logic [31:0] d;
         r = $urandom_range(0, 99);
         if (r < 60) begin
            step(0, 16'($urandom), 32'($urandom));
         end else if (r < 90) begin
            idx = $urandom_range(0, 3);
            a = 16'hFF00 | 16'(idx * 4) | 16'($urandom_range(0, 3));
            case (idx)
               0:       d = (32'($urandom) & 32'hFFFF_00F8) | 32'($urandom_range(0, 3) * 256)
                            | 32'($urandom_range(0, 7));
               1, 2:    d = 32'($urandom_range(0, 6));
               default: d = 32'($urandom);
            endcase
            step(1, a, d);
         end else begin
            a = 16'($urandom);
            if (a[15:4] == 12'hFF0) a[4] = 1'b1;
            step(1, a, 32'($urandom));
         end
         chk_rd($sformatf("rnd%0d_ctrl", n),  16'hFF00, m_ctrl());
         chk_rd($sformatf("rnd%0d_load", n),  16'hFF04, m_load);
         chk_rd($sformatf("rnd%0d_count", n), 16'hFF08, m_count);
         chk_rd($sformatf("rnd%0d_stat", n),  16'hFF0C, {31'h0, m_exp});
         chk($sformatf("rnd%0d_irq", n), {31'h0, irq}, {31'h0, m_exp & m_ie});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
